// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary systolic multiplier.
// It fetches A columns and B rows, skews them diagonally into the array,
// clears and runs the array, then streams the N*N results over valid/ready.
module systolic_ctrl #(
  parameter int N    = 6,
  parameter int DW   = 32,
  parameter int KMAX = 16,
  parameter int AW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [AW:0]             k_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    a_rd_en_o,
  output logic [AW-1:0]           a_rd_addr_o,
  input  logic [N*DW-1:0]         a_rd_data_i,
  output logic                    b_rd_en_o,
  output logic [AW-1:0]           b_rd_addr_o,
  input  logic [N*DW-1:0]         b_rd_data_i,
  output logic                    arr_clr_o,
  output logic [N*DW-1:0]         arr_a_o,
  output logic [N*DW-1:0]         arr_b_o,
  input  logic [N*N*2*DW-1:0]     arr_c_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [5:0]              res_idx_o,
  output logic [2*DW-1:0]         res_data_o
);

  // Feed counter must reach K + 2N - 2 for the largest K.
  localparam int         TW       = $clog2(KMAX + 2*N);
  localparam logic [5:0] IDX_LAST = 6'(N*N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_OUT} state_t;

  state_t        state_q;
  logic [AW:0]   k_q;
  logic [TW-1:0] t_q;
  logic [TW-1:0] t_last_d;
  logic [5:0]    idx_q;
  logic          done_q;
  logic          rd_en_d;
  logic          rd_vld_q;
  logic          clr_d;

  // Oversized inner dimensions are limited to what the operand buffers hold.
  function automatic logic [AW:0] clamp_k(input logic [AW:0] k);
    if (k > (AW+1)'(KMAX)) return (AW+1)'(KMAX);
    return k;
  endfunction

  // The last product reaches PE(N-1,N-1) at feed cycle K + 2N - 2.
  assign t_last_d = TW'(k_q) + TW'(2*N - 2);
  assign rd_en_d  = (state_q == S_FEED) && (t_q < TW'(k_q));
  assign clr_d    = rst | (state_q == S_CLEAR);

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign a_rd_en_o   = rd_en_d;
  assign b_rd_en_o   = rd_en_d;
  assign a_rd_addr_o = rd_en_d ? t_q[AW-1:0] : '0;
  assign b_rd_addr_o = rd_en_d ? t_q[AW-1:0] : '0;
  assign arr_clr_o   = clr_d;
  assign res_valid_o = (state_q == S_OUT);
  assign res_idx_o   = idx_q;
  assign res_data_o  = arr_c_i[int'(idx_q)*(2*DW) +: 2*DW];

  // Job sequencing: IDLE -> CLEAR -> FEED -> OUT, with K = 0 skipping FEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            k_q     <= clamp_k(k_len_i);
            t_q     <= '0;
            idx_q   <= '0;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state_q <= (k_q == '0) ? S_OUT : S_FEED;
        end
        S_FEED: begin
          if (t_q == t_last_d) begin
            t_q     <= '0;
            state_q <= S_OUT;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        S_OUT: begin
          if (res_ready_i) begin
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer read data is valid one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (rst) rd_vld_q <= 1'b0;
    else     rd_vld_q <= rd_en_d;
  end

  // Per-lane diagonal skew: lane i passes through i registers.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = rd_vld_q ? a_rd_data_i[i*DW +: DW] : '0;
    assign b_in = rd_vld_q ? b_rd_data_i[i*DW +: DW] : '0;

    if (i == 0) begin : g_direct
      assign arr_a_o[i*DW +: DW] = a_in;
      assign arr_b_o[i*DW +: DW] = b_in;
    end else begin : g_skew
      logic [DW-1:0] a_sr_q [i];
      logic [DW-1:0] b_sr_q [i];

      // Shift lane data toward the array; flushed on reset and CLEAR.
      always_ff @(posedge clk) begin
        if (clr_d) begin
          for (int d = 0; d < i; d++) begin
            a_sr_q[d] <= '0;
            b_sr_q[d] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_in;
          b_sr_q[0] <= b_in;
          for (int d = 1; d < i; d++) begin
            a_sr_q[d] <= a_sr_q[d-1];
            b_sr_q[d] <= b_sr_q[d-1];
          end
        end
      end

      assign arr_a_o[i*DW +: DW] = a_sr_q[i-1];
      assign arr_b_o[i*DW +: DW] = b_sr_q[i-1];
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand buffers and a behavioural PE grid around
// the sequencer; results are compared with a direct matrix product A*B.
module tb_systolic_ctrl;
  localparam int N    = 6;
  localparam int DW   = 32;
  localparam int KMAX = 16;
  localparam int AW   = 4;
  localparam int NN   = N*N;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [AW:0]          k_len;
  logic                 busy, done;
  logic                 a_rd_en, b_rd_en;
  logic [AW-1:0]        a_rd_addr, b_rd_addr;
  logic [N*DW-1:0]      a_rd_data = '0;
  logic [N*DW-1:0]      b_rd_data = '0;
  logic                 arr_clr;
  logic [N*DW-1:0]      arr_a, arr_b;
  logic [NN*2*DW-1:0]   arr_c;
  logic                 res_valid, res_ready;
  logic [5:0]           res_idx;
  logic [2*DW-1:0]      res_data;

  logic [DW-1:0]   A [N][KMAX];
  logic [DW-1:0]   B [KMAX][N];
  logic [63:0]     c_exp [NN];

  logic [DW-1:0]   pa  [N][N];
  logic [DW-1:0]   pb  [N][N];
  logic [63:0]     acc [N][N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .DW(DW), .KMAX(KMAX), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len),
    .busy_o(busy), .done_o(done),
    .a_rd_en_o(a_rd_en), .a_rd_addr_o(a_rd_addr), .a_rd_data_i(a_rd_data),
    .b_rd_en_o(b_rd_en), .b_rd_addr_o(b_rd_addr), .b_rd_data_i(b_rd_data),
    .arr_clr_o(arr_clr), .arr_a_o(arr_a), .arr_b_o(arr_b), .arr_c_i(arr_c),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_idx_o(res_idx), .res_data_o(res_data)
  );

  // Operand buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) for (int i = 0; i < N; i++) a_rd_data[i*DW +: DW] <= A[i][a_rd_addr];
    if (b_rd_en) for (int j = 0; j < N; j++) b_rd_data[j*DW +: DW] <= B[b_rd_addr][j];
  end

  function automatic logic [DW-1:0] a_in(int i, int j);
    if (j == 0) return arr_a[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(int i, int j);
    if (i == 0) return arr_b[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  // Output-stationary PE grid: a moves right, b moves down, each PE accumulates.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_clr) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= a_in(i, j);
          pb[i][j]  <= b_in(i, j);
          acc[i][j] <= acc[i][j] + 64'(a_in(i, j)) * 64'(b_in(i, j));
        end
      end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        arr_c[(r*N + c)*64 +: 64] = acc[r][c];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] ref_c(int r, int c, int kk);
    logic [63:0] s = '0;
    for (int k = 0; k < kk; k++) s += 64'(A[r][k]) * 64'(B[k][c]);
    return s;
  endfunction

  task automatic fill_const(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        A[i][k] = v;
        B[k][i] = v;
      end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        A[i][k] = $urandom();
        B[k][i] = $urandom();
      end
  endtask

  // One job: start (unless already issued), latency, all N*N words, done pulse.
  task automatic run_job(input int klen, input int rmode, input bit pre_started,
                         input bit spurious, input bit chain, input int next_klen,
                         input bit use_fixed, input logic [63:0] fixed_val);
    int keff, exp_lat, lat, accepted, idx_exp, guard, ph;
    bit r, stalled;
    logic [63:0] held_data;
    logic [5:0]  held_idx;
    logic [3:0]  pat;
    pat      = 4'b1001;
    ph       = 0;
    stalled  = 1'b0;
    held_data = '0;
    held_idx  = '0;
    keff    = (klen > KMAX) ? KMAX : klen;
    exp_lat = (keff == 0) ? 2 : 2 + keff + 2*N - 1;
    for (int r0 = 0; r0 < N; r0++)
      for (int c0 = 0; c0 < N; c0++)
        c_exp[r0*N + c0] = use_fixed ? fixed_val : ref_c(r0, c0, keff);

    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      k_len = klen[AW:0];
    end
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    chk("busy_after_start", 256'(busy), 256'(1));
    chk("clr_after_start", 256'(arr_clr), 256'(1));

    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (spurious && lat == 3) begin start = 1'b1; k_len = 5'd1; end
      if (spurious && lat == 4) start = 1'b0;
    end
    if (!res_valid) begin
      chk("valid_timeout", 256'(res_valid), 256'(1));
      return;
    end
    chk("first_valid_latency", 256'(lat), 256'(exp_lat));

    accepted = 0;
    idx_exp  = 0;
    guard    = 0;
    while (accepted < NN && guard < 2000) begin
      if (guard > 0) @(negedge clk);
      guard++;
      if (res_valid) begin
        if (stalled) begin
          chk("hold_data", 256'(res_data), 256'(held_data));
          chk("hold_idx", 256'(res_idx), 256'(held_idx));
        end
        chk("res_idx", 256'(res_idx), 256'(idx_exp));
        chk($sformatf("res_data[%0d]", idx_exp), 256'(res_data), 256'(c_exp[idx_exp]));
      end else begin
        chk("valid_gap", 256'(res_valid), 256'(1));
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin r = pat[ph % 4]; ph++; end
      endcase
      res_ready = r;
      stalled   = res_valid && !r;
      held_data = res_data;
      held_idx  = res_idx;
      if (res_valid && r) begin
        accepted++;
        idx_exp++;
      end
    end
    if (accepted < NN) begin
      chk("collect_timeout", 256'(accepted), 256'(NN));
      return;
    end

    @(negedge clk);
    chk("done_pulse", 256'(done), 256'(1));
    chk("idle_at_done", 256'(busy), 256'(0));
    chk("valid_low_at_done", 256'(res_valid), 256'(0));
    res_ready = 1'b0;
    if (chain) begin
      start = 1'b1;
      k_len = next_klen[AW:0];
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 256'(done), 256'(0));
      chk("no_queued_start", 256'(busy), 256'(0));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    res_ready = 1'b0;
    fill_const('0);
    repeat (3) @(negedge clk);

    chk("rst_arr_clr", 256'(arr_clr), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_a_rd_en", 256'(a_rd_en), 256'(0));
    chk("rst_b_rd_en", 256'(b_rd_en), 256'(0));
    chk("rst_a_addr", 256'(a_rd_addr), 256'(0));
    chk("rst_b_addr", 256'(b_rd_addr), 256'(0));
    chk("rst_arr_a", 256'(arr_a), 256'(0));
    chk("rst_arr_b", 256'(arr_b), 256'(0));
    chk("rst_res_valid", 256'(res_valid), 256'(0));
    chk("rst_res_idx", 256'(res_idx), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_clr", 256'(arr_clr), 256'(0));
    chk("post_rst_busy", 256'(busy), 256'(0));

    // All-ones, K = 4: every word is 4.
    fill_const(32'd1);
    run_job(4, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 64'd4);

    // Identity A, B[k][j] = 6k+j+1: C equals B; latency 19.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        A[i][k] = (i == k) ? 32'd1 : 32'd0;
        B[k][i] = 32'(6*k + i + 1);
      end
    run_job(6, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 64'd0);

    // Overflow wrap, then back-to-back start in the done cycle.
    fill_const(32'hFFFF_FFFF);
    run_job(2, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, 64'hFFFF_FFFC_0000_0002);
    fill_rand();
    run_job(5, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 64'd0);

    // Random backpressure plus a start issued while busy.
    fill_rand();
    run_job(9, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 64'd0);

    // Reset during FEED at t = 5.
    fill_rand();
    @(negedge clk);
    start = 1'b1;
    k_len = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("feed_rd_en_t5", 256'(a_rd_en), 256'(1));
    chk("feed_a_addr_t5", 256'(a_rd_addr), 256'(5));
    chk("feed_b_addr_t5", 256'(b_rd_addr), 256'(5));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_clr", 256'(arr_clr), 256'(1));
    chk("midrst_arr_a", 256'(arr_a), 256'(0));
    chk("midrst_arr_b", 256'(arr_b), 256'(0));
    chk("midrst_rd_en", 256'(a_rd_en), 256'(0));
    chk("midrst_done", 256'(done), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("after_midrst_busy", 256'(busy), 256'(0));
    chk("after_midrst_done", 256'(done), 256'(0));
    fill_const(32'd1);
    run_job(3, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 64'd3);

    // K = 0 yields all zeros; K = 20 behaves as K = 16.
    fill_rand();
    run_job(0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 64'd0);
    fill_rand();
    run_job(20, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
